gcd_job_arbiter: RTL

- Shares one repeated-subtraction GCD engine (datapath + controller pair with a start/done handshake) between N requesters.
- Round-robin arbitration selects a requester and captures its operand pair.
- Sequences the engine through start, wait and result, then returns the result to the winning requester.
- Short-circuits zero operands, which would stall a subtraction engine.
- Enforces a watchdog timeout and aborts a hung job.

---
 rtl/gcd_pkg.sv | 21 ++
 rtl/gcd_job_arbiter_if.sv | 33 +++
 rtl/gcd_job_arbiter_rr_arbiter.sv | 36 +++
 rtl/gcd_job_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD job arbiter.
package gcd_pkg;

    // Job sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int DEF_W       = 16;
    localparam int DEF_TIMEOUT = 1024;
    localparam int DEF_CNT_W   = $clog2(DEF_TIMEOUT);

    // Watchdog width: clog2(TIMEOUT) bits always holds TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/gcd_job_arbiter_if.sv
// Requester and engine signals of the GCD job arbiter.
// slave = the arbiter, master = requesters plus engine.
interface gcd_job_arbiter_if #(
    parameter int N = 4,
    parameter int W = gcd_pkg::DEF_W
);
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           busy;
    logic           eng_start;
    logic [W-1:0]   eng_a;
    logic [W-1:0]   eng_b;
    logic           eng_abort;
    logic           eng_done;
    logic [W-1:0]   eng_result;

    modport slave (
        input  req, req_a, req_b, eng_done, eng_result,
        output gnt, rsp_valid, rsp_data, rsp_err, busy,
               eng_start, eng_a, eng_b, eng_abort
    );

    modport master (
        output req, req_a, req_b, eng_done, eng_result,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy,
               eng_start, eng_a, eng_b, eng_abort
    );
endinterface

// File: rtl/gcd_job_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [PW-1:0] win_idx,
    output logic          any
);
    int            sum;
    logic [PW-1:0] pos;
    logic          found;

    // Walk the N positions starting at ptr; the first requester hit wins.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        sum     = 0;
        pos     = '0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum = int'(ptr) + k;
            if (sum >= N) sum = sum - N;
            pos = PW'(sum);
            if (!found && req[pos]) begin
                found       = 1'b1;
                win_idx     = pos;
                win_oh[pos] = 1'b1;
            end
        end
        any = found;
    end
endmodule

// File: rtl/gcd_job_arbiter.sv
// Shares one start/done GCD engine among N requesters: round-robin grant,
// operand capture, engine sequencing with watchdog, one-hot response.
module gcd_job_arbiter
    import gcd_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic            clk,
    input logic            rst_n,
    gcd_job_arbiter_if.slave bus
);
    localparam int            PW       = (N > 1) ? $clog2(N) : 1;
    localparam int            CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [N-1:0]  ONE      = {{(N-1){1'b0}}, 1'b1};

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] id;
    logic [W-1:0]  result;
    logic          err;
    logic [CW-1:0] cnt;

    logic [N-1:0]  win_oh;
    logic [PW-1:0] win_idx;
    logic          any;
    logic [PW-1:0] next_ptr;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;

    rr_arbiter #(.N(N), .PW(PW)) u_rr (
        .req     (bus.req),
        .ptr     (rr_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (any)
    );

    assign sel_a    = bus.req_a[int'(win_idx)*W +: W];
    assign sel_b    = bus.req_b[int'(win_idx)*W +: W];
    assign next_ptr = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;

    // Job sequencer. eng_a/eng_b double as the operand capture registers so
    // they stay stable from ISSUE through WAIT. Pulsed outputs default low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            id            <= '0;
            result        <= '0;
            err           <= 1'b0;
            cnt           <= '0;
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.eng_start <= 1'b0;
            bus.eng_a     <= '0;
            bus.eng_b     <= '0;
            bus.eng_abort <= 1'b0;
        end else begin
            bus.gnt       <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.eng_start <= 1'b0;
            bus.eng_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        bus.gnt   <= win_oh;
                        id        <= win_idx;
                        bus.eng_a <= sel_a;
                        bus.eng_b <= sel_b;
                        rr_ptr    <= next_ptr;
                        bus.busy  <= 1'b1;
                        // A zero operand would never converge by subtraction;
                        // gcd(x,0) = x, so the answer is simply A | B.
                        if (sel_a == '0 || sel_b == '0) begin
                            result <= sel_a | sel_b;
                            err    <= 1'b0;
                            state  <= RESP;
                        end else begin
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    bus.eng_start <= 1'b1;
                    cnt           <= '0;
                    state         <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // A completion in the last watchdog cycle still wins.
                    if (bus.eng_done) begin
                        result <= bus.eng_result;
                        err    <= 1'b0;
                        state  <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        bus.eng_abort <= 1'b1;
                        result        <= '0;
                        err           <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    bus.rsp_valid <= ONE << id;
                    bus.rsp_data  <= result;
                    bus.rsp_err   <= err;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
